// File: rtl/hybrid_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hybrid_adder_pkg
// Purpose  : Shared definitions for the sequential hybrid adder: FSM state
//            encoding, segment-count helper and parameter sanity check.
// Revision : 1.0  initial release
// ============================================================================
package hybrid_adder_pkg;

    // FSM state encoding (explicit 2-bit width)
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Number of clocks (segments) needed for one operation.
    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

    // WIDTH must be a whole number of SEG-bit segments and at least 2 bits.
    function automatic bit params_ok(input int width, input int seg);
        return (seg > 0) && (width >= 2) && (seg <= width) && ((width % seg) == 0);
    endfunction

    // Width of the segment index; kept at 1 bit for the single-segment case.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hybrid_adder_seq_cla_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice
// Purpose  : Combinational SEG-bit carry-lookahead adder slice. Each internal
//            carry is formed directly from the generate/propagate terms and
//            the slice carry-in rather than rippled through lower bits.
// Ports    : a, b   [SEG-1:0] in  - operand bits
//            cin              in  - carry into bit 0
//            sum    [SEG-1:0] out - a + b + cin (low SEG bits)
//            cout             out - carry out of the slice MSB
//            c_msb            out - carry into the slice MSB (for overflow)
// Revision : 1.0  initial release
// ============================================================================
module cla_slice #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    for (genvar i = 0; i < SEG; i++) begin : g_carry
        logic w_ci;
        logic w_term;
        always_comb begin
            w_ci   = cin & (&w_p[i:0]);
            w_term = 1'b0;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_ci = w_ci | w_term;
            end
        end
        assign w_c[i+1] = w_ci;
    end

    assign sum   = w_p ^ w_c[SEG-1:0];
    assign cout  = w_c[SEG];
    assign c_msb = w_c[SEG-1];

endmodule
`default_nettype wire

// File: rtl/hybrid_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : hybrid_adder_seq
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor. One SEG-bit lookahead
//            slice is reused for NSEG = WIDTH/SEG clocks, with the segment
//            carry registered between clocks. Valid/ready on both sides.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid / in_ready   - operand handshake (X, Y, C0, SUB)
//            X, Y [WIDTH-1:0]      - operands
//            C0                    - carry-in (add) / borrow-in (subtract)
//            SUB                   - 0: X+Y+C0, 1: X-Y-C0
//            out_valid / out_ready - result handshake (S, Cout, V)
//            S [WIDTH-1:0]         - sum / difference
//            Cout                  - carry-out (add) / NOT borrow-out (sub)
//            V                     - signed overflow
// Revision : 1.0  initial release
// ============================================================================
module hybrid_adder_seq
    import hybrid_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             C0,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NSEG  = nseg(WIDTH, SEG);
    localparam int IDX_W = idx_width(NSEG);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NSEG - 1);

    if (!params_ok(WIDTH, SEG)) begin : g_param_check
        $error("hybrid_adder_seq: WIDTH must be >= 2 and a multiple of SEG");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_step;
    logic [IDX_W-1:0] r_seg_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_v;

    logic [SEG-1:0]   w_a;
    logic [SEG-1:0]   w_b;
    logic [SEG-1:0]   w_sum;
    logic             w_cout;
    logic             w_c_msb;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                w_step = 1'b1;
                if (r_seg_idx == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes so reset drives them at once.
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);

    // ------------------------------------------------------------------
    // Shared lookahead slice, fed from the latched operands only
    // ------------------------------------------------------------------
    assign w_a = r_x[r_seg_idx*SEG +: SEG];
    assign w_b = r_y[r_seg_idx*SEG +: SEG];

    cla_slice #(
        .SEG (SEG)
    ) u_cla_slice (
        .a     (w_a),
        .b     (w_b),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    // ------------------------------------------------------------------
    // Datapath. Subtraction is folded in at the latch: Y is stored
    // inverted and the borrow-in becomes carry-in ~C0, so the RUN phase
    // is a plain addition and SUB itself need not be kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_carry   <= 1'b0;
            r_seg_idx <= '0;
            r_s       <= '0;
            r_cout    <= 1'b0;
            r_v       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x       <= X;
                r_y       <= SUB ? ~Y : Y;
                r_carry   <= SUB ? ~C0 : C0;
                r_seg_idx <= '0;
            end
            if (w_step) begin
                r_s[r_seg_idx*SEG +: SEG] <= w_sum;
                r_carry                   <= w_cout;
                if (r_seg_idx == c_LAST) begin
                    r_cout    <= w_cout;
                    r_v       <= w_c_msb ^ w_cout;
                    r_seg_idx <= '0;
                end else begin
                    r_seg_idx <= r_seg_idx + IDX_W'(1);
                end
            end
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign V    = r_v;

endmodule
`default_nettype wire
